// File: rtl/run_monitor.sv
// Run monitor FSM: gates CPU run enable and tracks cycle budget, PC limit and stalls.
// Optional stall counter and hang detector are compiled in with STALL_COUNT_EN.
module run_monitor #(
  parameter int PC_W       = 32,
  parameter int CYC_W      = 16,
  parameter int HANG_LIMIT = 64
) (
  input  logic             clk,
  input  logic             initPC,
  input  logic             start,
  input  logic             abort,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  pc_lim,
  input  logic [CYC_W-1:0] max_cycles,
  output logic             cpu_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             hang,
  output logic [CYC_W-1:0] cycle_count,
  output logic [CYC_W-1:0] stall_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, TIMEOUT} state_t;

  state_t           state, state_nx;
  logic [CYC_W-1:0] cyc_q, cyc_nx, cyc_inc;
  logic [CYC_W-1:0] stall_q, stall_nx, stall_inc;
  logic             hang_q, hang_nx;
  logic             hang_det;
  logic             clr, upd;

`ifdef STALL_COUNT_EN
  logic [PC_W-1:0] prev_q;
  logic            seen_q;
  logic [31:0]     consec_q, consec_inc;
  logic            is_stall;

  // The first RUN cycle only captures the PC; it can never be a stall.
  assign is_stall   = seen_q && (pc == prev_q);
  assign consec_inc = is_stall ? consec_q + 32'd1 : 32'd0;
  assign hang_det   = (consec_inc == HANG_LIMIT);
  assign stall_inc  = (is_stall && !(&stall_q)) ?
                      stall_q + 1'b1 : stall_q;

  always_ff @(posedge clk or posedge initPC) begin
    if (initPC) begin
      prev_q   <= '0;
      seen_q   <= 1'b0;
      consec_q <= '0;
    end else if (clr) begin
      prev_q   <= '0;
      seen_q   <= 1'b0;
      consec_q <= '0;
    end else if (upd) begin
      prev_q   <= pc;
      seen_q   <= 1'b1;
      consec_q <= consec_inc;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (HANG_LIMIT != 0) | upd;
  assign hang_det   = 1'b0;
  assign stall_inc  = '0;
`endif

  always_comb begin
    state_nx = state;
    cyc_nx   = cyc_q;
    stall_nx = stall_q;
    hang_nx  = hang_q;
    clr      = 1'b0;
    upd      = 1'b0;
    cyc_inc  = (&cyc_q) ? cyc_q : cyc_q + 1'b1;
    unique case (state)
      IDLE: begin
        if (!abort && start) begin
          state_nx = RUN;
          clr      = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_nx = IDLE;
        end else begin
          upd      = 1'b1;
          stall_nx = stall_inc;
          if (pc >= pc_lim) begin
            state_nx = DONE;
          end else if (hang_det) begin
            state_nx = TIMEOUT;
            hang_nx  = 1'b1;
          end else begin
            cyc_nx = cyc_inc;
            if (max_cycles != '0 && cyc_inc == max_cycles)
              state_nx = TIMEOUT;
          end
        end
      end
      default: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (start) begin
          state_nx = RUN;
          clr      = 1'b1;
        end
      end
    endcase
    if (clr) begin
      cyc_nx   = '0;
      stall_nx = '0;
      hang_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge initPC) begin
    if (initPC) begin
      state   <= IDLE;
      cyc_q   <= '0;
      stall_q <= '0;
      hang_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      cyc_q   <= cyc_nx;
      stall_q <= stall_nx;
      hang_q  <= hang_nx;
    end
  end

  assign cpu_en      = (state == RUN);
  assign busy        = (state == RUN);
  assign done        = (state == DONE);
  assign timeout     = (state == TIMEOUT);
  assign hang        = hang_q;
  assign cycle_count = cyc_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_run_monitor.sv
// Directed table-driven bench for run_monitor plus multi-cycle corner sequences.
module tb_run_monitor;

`ifdef STALL_COUNT_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        initPC = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] pc_lim = '0;
  logic [15:0] max_cycles = '0;
  logic        cpu_en, busy, done, timeout, hang;
  logic [15:0] cycle_count, stall_count;

  int total = 0;
  int bad   = 0;

  run_monitor #(.PC_W(32), .CYC_W(16), .HANG_LIMIT(64)) dut (
    .clk(clk), .initPC(initPC), .start(start), .abort(abort),
    .pc(pc), .pc_lim(pc_lim), .max_cycles(max_cycles),
    .cpu_en(cpu_en), .busy(busy), .done(done), .timeout(timeout),
    .hang(hang), .cycle_count(cycle_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        ab;
    logic [31:0] pc;
    logic [31:0] lim;
    logic [15:0] mx;
    logic [4:0]  fl;
    logic [15:0] cc;
    logic [15:0] sc;
  } vec_t;

  localparam logic [4:0] F_IDLE = 5'b00000;
  localparam logic [4:0] F_RUN  = 5'b11000;
  localparam logic [4:0] F_DONE = 5'b00100;
  localparam logic [4:0] F_TO   = 5'b00010;

  vec_t tbl[19];

  function automatic vec_t mk(logic st, logic ab, logic [31:0] p,
                              logic [15:0] mx, logic [4:0] fl,
                              logic [15:0] cc, logic [15:0] sc);
    vec_t v;
    v.st = st; v.ab = ab; v.pc = p; v.lim = 32'h100; v.mx = mx;
    v.fl = fl; v.cc = cc; v.sc = sc;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] flags();
    return {cpu_en, busy, done, timeout, hang};
  endfunction

  task automatic do_start(logic [31:0] p, logic [31:0] lim,
                          logic [15:0] mx);
    pc = p; pc_lim = lim; max_cycles = mx;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [15:0] s1;
    int n;
    s1 = STALL_ON ? 16'd1 : 16'd0;
    tbl[0]  = mk(1, 0, 32'h0,   16'd0, F_RUN,  16'd0, 16'd0);
    tbl[1]  = mk(0, 0, 32'h4,   16'd0, F_RUN,  16'd1, 16'd0);
    tbl[2]  = mk(1, 0, 32'h8,   16'd0, F_RUN,  16'd2, 16'd0);
    tbl[3]  = mk(0, 0, 32'hC,   16'd0, F_RUN,  16'd3, 16'd0);
    tbl[4]  = mk(0, 0, 32'h100, 16'd0, F_DONE, 16'd3, 16'd0);
    tbl[5]  = mk(0, 0, 32'h104, 16'd0, F_DONE, 16'd3, 16'd0);
    tbl[6]  = mk(1, 1, 32'h0,   16'd0, F_IDLE, 16'd3, 16'd0);
    tbl[7]  = mk(0, 0, 32'h0,   16'd0, F_IDLE, 16'd3, 16'd0);
    tbl[8]  = mk(1, 0, 32'h0,   16'd3, F_RUN,  16'd0, 16'd0);
    tbl[9]  = mk(0, 0, 32'h4,   16'd3, F_RUN,  16'd1, 16'd0);
    tbl[10] = mk(0, 0, 32'h8,   16'd3, F_RUN,  16'd2, 16'd0);
    tbl[11] = mk(0, 0, 32'hC,   16'd3, F_TO,   16'd3, 16'd0);
    tbl[12] = mk(0, 0, 32'h10,  16'd3, F_TO,   16'd3, 16'd0);
    tbl[13] = mk(1, 0, 32'h100, 16'd3, F_RUN,  16'd0, 16'd0);
    tbl[14] = mk(0, 1, 32'h0,   16'd3, F_IDLE, 16'd0, 16'd0);
    tbl[15] = mk(1, 0, 32'h10,  16'd0, F_RUN,  16'd0, 16'd0);
    tbl[16] = mk(0, 0, 32'h10,  16'd0, F_RUN,  16'd1, 16'd0);
    tbl[17] = mk(0, 0, 32'h10,  16'd0, F_RUN,  16'd2, s1);
    tbl[18] = mk(0, 1, 32'h10,  16'd0, F_IDLE, 16'd2, s1);

    // reset state
    #1;
    check("reset_outputs", {flags(), cycle_count, stall_count}, '0);
    tick();
    initPC = 1'b0;
    tick();
    tick();
    check("idle_after_reset", {flags(), cycle_count}, '0);

    for (int i = 0; i < 19; i++) begin
      start = tbl[i].st; abort = tbl[i].ab; pc = tbl[i].pc;
      pc_lim = tbl[i].lim; max_cycles = tbl[i].mx;
      tick();
      check($sformatf("vec%0d", i), {flags(), cycle_count, stall_count},
            {tbl[i].fl, tbl[i].cc, tbl[i].sc});
    end
    start = 1'b0; abort = 1'b0;

    // normal finish: 21 RUN cycles to reach the limit
    do_start(32'h00400000, 32'h00400054, 16'd5000);
    n = -1;
    for (int i = 0; i < 40; i++) begin
      pc = 32'h00400000 + 32'(4 * i);
      tick();
      if (done) begin n = i; break; end
      if (!cpu_en) begin n = -2; break; end
    end
    check("finish_edges", 64'(n), 64'd21);
    check("finish_state", {flags(), cycle_count}, {F_DONE, 16'd21});

    // budget timeout with varying PC below the limit
    do_start(32'h00400000, 32'h00400054, 16'd10);
    for (int i = 0; i < 40 && busy; i++) begin
      pc = (i % 2 == 0) ? 32'h00400004 : 32'h00400000;
      tick();
    end
    check("budget_state", {flags(), cycle_count}, {F_TO, 16'd10});

    // PC hits the limit on the edge the budget would expire
    do_start(32'h0, 32'h8, 16'd3);
    pc = 32'h0; tick();
    pc = 32'h4; tick();
    pc = 32'h8; tick();
    check("simul_state", {flags(), cycle_count}, {F_DONE, 16'd2});

    // PC held constant
    do_start(32'h00400010, 32'h00400054, 16'd100);
    for (int i = 0; i < 200 && busy; i++) tick();
    if (STALL_ON)
      check("hang_state", {flags(), cycle_count, stall_count},
            {F_TO | 5'b00001, 16'd64, 16'd64});
    else
      check("hang_state", {flags(), cycle_count, stall_count},
            {F_TO, 16'd100, 16'd0});

    // asynchronous reset mid-run at cycle_count 7
    do_start(32'h0, 32'h1000, 16'd0);
    for (int i = 0; i < 7; i++) begin
      pc = 32'(4 * (i + 1));
      tick();
    end
    check("pre_reset_count", {flags(), cycle_count}, {F_RUN, 16'd7});
    #2 initPC = 1'b1;
    #1;
    check("async_reset", {flags(), cycle_count, stall_count}, '0);
    tick();
    initPC = 1'b0;
    tick();
    tick();
    check("idle_hold", {flags(), cycle_count}, '0);
    do_start(32'h0, 32'h1000, 16'd0);
    check("fresh_run", {flags(), cycle_count}, {F_RUN, 16'd0});
    pc = 32'h4; tick();
    check("fresh_count", {flags(), cycle_count}, {F_RUN, 16'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/run_monitor.md
RUN_MONITOR -- requirements
Module: run_monitor

Interface
REQ-001 Parameter PC_W, default 32, width of the monitored program counter.
REQ-002 Parameter CYC_W, default 16, width of cycle counter and cycle budget.
REQ-003 Parameter HANG_LIMIT, default 64, consecutive unchanged-PC cycles that declare a hang (used only with STALL_COUNT_EN).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 initPC  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle request to begin a run.
REQ-007 abort  input  1  forces return to IDLE.
REQ-008 pc  input  PC_W  current fetch PC of the CPU under control.
REQ-009 pc_lim  input  PC_W  completion address; sampled every RUN cycle.
REQ-010 max_cycles  input  CYC_W  cycle budget; 0 = unlimited; sampled every RUN cycle.
REQ-011 cpu_en  output  1  run enable to the CPU; high only in RUN.
REQ-012 busy  output  1  high in RUN.
REQ-013 done  output  1  high in DONE.
REQ-014 timeout  output  1  high in TIMEOUT.
REQ-015 hang  output  1  high in TIMEOUT when caused by the hang detector.
REQ-016 cycle_count  output  CYC_W  RUN cycles elapsed in the current or last run.
REQ-017 stall_count  output  CYC_W  RUN cycles where pc equalled its previous-cycle value.

Function
REQ-018 The block SHALL be a Moore FSM with states IDLE, RUN, DONE, TIMEOUT; all outputs registered or decoded from state only.
REQ-019 IDLE: start=1 SHALL go to RUN next edge and clear cycle_count, stall_count, hang and the internal consecutive-stall counter.
REQ-020 RUN, evaluated each edge in priority order: abort -> IDLE; pc >= pc_lim (unsigned) -> DONE with cycle_count unchanged; hang detected -> TIMEOUT with hang=1; otherwise cycle_count increments by 1.
REQ-021 In RUN, if max_cycles != 0 and the incremented cycle_count equals max_cycles, the state SHALL go to TIMEOUT on that edge (hang=0).
REQ-022 cycle_count SHALL saturate at all-ones, never wrap; with max_cycles=0 the run continues after saturation until pc_lim or abort.
REQ-023 start in RUN SHALL be ignored.
REQ-024 DONE/TIMEOUT: outputs and counters SHALL hold; start -> RUN with counters cleared as REQ-019; abort -> IDLE with counters held.
REQ-025 abort SHALL take priority over start in every state.
REQ-026 cpu_en SHALL be asserted the first cycle after the start edge and deassert the cycle after the DONE/TIMEOUT transition edge.

Reset
REQ-027 initPC=1 SHALL immediately force IDLE, cpu_en=0, busy=0, done=0, timeout=0, hang=0, cycle_count=0, stall_count=0, and clear the internal previous-PC and consecutive-stall registers, including mid-run.
REQ-028 After initPC falls, the block SHALL remain in IDLE until start.

Configuration
REQ-029 Macro STALL_COUNT_EN SHALL compile in the stall counter and hang detector.
REQ-030 With STALL_COUNT_EN: in RUN, pc==previous pc increments stall_count (saturating) and the consecutive counter; a change clears the consecutive counter; reaching HANG_LIMIT is "hang detected"; first RUN cycle never counts as a stall.
REQ-031 Without STALL_COUNT_EN: stall_count and hang SHALL be tied 0, hang detection never fires, ports unchanged.

Verification
REQ-032 Normal finish: pc_lim=0x00400054, max_cycles=5000, pc steps +4 from 0x00400000 each cycle -> done=1 after 21 RUN cycles, cycle_count=21, cpu_en low next cycle.
REQ-033 Budget: pc_lim=0x00400054, max_cycles=10, pc stuck below limit and varying -> timeout=1, hang=0, cycle_count=10.
REQ-034 Simultaneous: pc reaches pc_lim on the edge cycle_count would hit max_cycles -> done=1, timeout=0.
REQ-035 Hang (STALL_COUNT_EN, HANG_LIMIT=64): pc held at 0x00400010 -> timeout=1, hang=1, stall_count=64; rebuild without macro -> stall_count=0, hang=0, run continues to budget.
REQ-036 Reset mid-run: assert initPC asynchronously at cycle_count=7 -> all outputs 0 without a clock edge; start after release -> fresh run from cycle_count=0.
REQ-037 abort and start together in DONE -> IDLE; start alone in RUN -> no counter clear.
